iph_sweep_scheduler: RTL and testbench
======================================

# iph_sweep_scheduler

Sequences one shared, fully pipelined photocurrent (Iph) datapath across `N_CH` PV channels. On each `start` it snapshots the per-channel irradiance and temperature operands and issues one enabled channel per cycle into the datapath. It tags every issue, routes each returning result into that channel's result register, and pulses `sweep_done` when the sweep has drained. It sits between the PV-array operand source and the Iph datapath; the shared constants (`Np_Isref/Sref`, `Tref`, `Np_Isref_J`) are wired to the datapath directly, not through this block.

## Interface
- `N_CH`, 4: number of channels, 2..16.
- `LAT`, 19: datapath latency from `iss_vld` to `dp_done`.
- `SINGLE`, 32: IEEE-754 single word width.
- `TW`, `$clog2(N_CH)`: tag width, derived.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: **asynchronous, active-low** reset. The datapath clear is tied to `~rst`.
- `start` in 1: sweep request pulse.
- `ch_en` in `N_CH`: channel enable mask, sampled with `start`.
- `S_all` in `N_CH*SINGLE`: irradiance per channel; channel k is bits `[k*SINGLE +: SINGLE]`.
- `T_all` in `N_CH*SINGLE`: cell temperature per channel, same packing.
- `iss_vld` out 1: drives datapath `sta`.
- `iss_S`, `iss_T` out `SINGLE`: operands to the datapath.
- `dp_done` in 1: datapath `done_sig`.
- `dp_Iph` in `SINGLE`: datapath result.
- `Iph_all` out `N_CH*SINGLE`: per-channel result registers.
- `Iph_vld` out `N_CH`: per-channel result updated in the current sweep.
- `busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse.
- `align_err` out 1: sticky tag/done mismatch flag.

## Operation
- FSM states: `IDLE`, `ISSUE`, `DRAIN`, `FIN`.
- `IDLE` + `start`:
  - Snapshot `S_all`, `T_all`, `ch_en` into shadow registers.
  - Clear `Iph_vld`, set `busy`.
  - Go to `ISSUE`; if the mask is zero, go directly to `FIN`.
- `ISSUE`:
  - Each cycle, issue the lowest-index enabled channel not yet issued.
  - Drive `iss_vld`=1 and `iss_S`/`iss_T` from the shadow registers.
  - Push `{1, ch}` into a `LAT`-deep tag pipe.
  - After the last enabled channel, go to `DRAIN`.
  - No bubbles between enabled channels.
- `DRAIN`: wait until the tag pipe holds no valid entries, then go to `FIN`.
- `FIN`:
  - Pulse `sweep_done`, clear `busy`.
  - If a pending start is set, clear it, resnapshot, and re-enter `ISSUE` next cycle.
  - Otherwise go to `IDLE`.
- Writeback: when the tag-pipe head is valid, write `dp_Iph` to `Iph_all[tag]` and set `Iph_vld[tag]`. This is independent of FSM state.
- `align_err`: set when `dp_done` differs from head-valid in any cycle. Cleared only by reset. A result with no valid tag is dropped.
- `start` while `busy`: set a one-deep pending flag. Additional starts are lost.
- `start` in the same cycle as `FIN`: treated as pending.
- `iss_S`/`iss_T` hold their last value when `iss_vld`=0.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in `IDLE`, tag pipe empty, pending cleared, shadow registers 0.
- `start` sampled at edge 0. First `iss_vld` in cycle 1.
- The j-th issue (j = 0..M-1, where M is the popcount of the mask) occurs in cycle 1+j. Its result is written at the end of cycle 1+j+`LAT`.
- `sweep_done` occurs in cycle M+`LAT`+1. With M=0 it occurs in cycle 1.
- Reset mid-sweep: everything clears immediately and in-flight results are discarded.
- Back-to-back sweeps: the second sweep's first issue is the cycle after `sweep_done`.

## Configuration
- `IPH_SCHED_CLAMP_EN`:
  - Defined: a result with sign bit 1 is written as `32'h00000000`. NaN/Inf pass through unchanged.
  - Undefined: `dp_Iph` is written unmodified.

## Structure
- Shared package `iph_pkg`: `SINGLE`, the FSM state enum, `FP_ZERO`, and the default `LAT`.
- One sub-module, `iph_tag_pipe`: a `LAT`-deep shift register of `{valid, tag}`, cleared by `rst`, exposing the head entry and an any-valid flag.

## Test plan
- Basic sweep: `ch_en`=4'b1111, `S_all` ch0..3 = 1000.0/800.0/600.0/400.0 (`447A0000`/`44480000`/`44160000`/`43C80000`), `LAT`=19, bench datapath model.
  - `iss_vld` high in cycles 1–4, channels 0..3 in order.
  - Results written in cycles 20–23, `sweep_done` in cycle 24.
  - `Iph_all` matches the model; `Iph_vld`=4'b1111.
- Sparse mask 4'b1010: issues in cycles 1–2 for ch1, ch3; `sweep_done` in cycle 22; `Iph_vld`=4'b1010.
- Zero mask: `sweep_done` in cycle 1, no `iss_vld`.
- Pending start: second `start` in cycle 5 of a full sweep.
  - Exactly one extra sweep runs, with its first issue in cycle 25.
  - A third `start` in cycle 6 is ignored.
- Reset mid-sweep: `rst` low in cycle 10, released in cycle 12.
  - All outputs 0, no writeback in cycles 20–23, `align_err`=0.
- Clamp (macro defined): model returns `BF800000` (-1.0) for ch2.
  - `Iph_all` ch2 = `00000000`.
  - With the macro undefined, ch2 = `BF800000`.
- Alignment error: inject a spurious `dp_done` in cycle 30 → `align_err`=1 and held until reset.

Source files
------------

// File: rtl/iph_pkg.sv
// Shared constants and types for the Iph sweep scheduler.
package iph_pkg;

  localparam int unsigned SINGLE      = 32;
  localparam int unsigned LAT_DEFAULT = 19;

  localparam logic [SINGLE-1:0] FP_ZERO = '0;

  // Exponent field of an IEEE-754 single word.
  localparam int unsigned FP_EXP_MSB = 30;
  localparam int unsigned FP_EXP_LSB = 23;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } sched_state_e;

endpackage

// File: rtl/iph_tag_pipe.sv
// LAT-deep shift register of {valid, tag} that tracks issues through the datapath.
// The head entry lines up with the datapath's done strobe. o_inflight reports valid
// entries behind the head, i.e. results that still have to retire after this cycle.
module iph_tag_pipe #(
  parameter int unsigned LAT = 19,
  parameter int unsigned TW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [TW-1:0] i_tag,
  output logic          o_head_vld,
  output logic [TW-1:0] o_head_tag,
  output logic          o_inflight
);

  // Every stage except the head.
  localparam logic [LAT-1:0] BodyMask = {LAT{1'b1}} >> 1;

  logic [LAT-1:0]         r_vld;
  logic [LAT-1:0][TW-1:0] r_tag;

  // Shift one stage per cycle; stage 0 takes the current issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_tag <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_tag[0] <= i_tag;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_head_vld = r_vld[LAT-1];
  assign o_head_tag = r_tag[LAT-1];
  assign o_inflight = |(r_vld & BodyMask);

endmodule

// File: rtl/iph_sweep_scheduler.sv
// Sequences one shared pipelined Iph datapath across N_CH PV channels.
// Optional feature macro: IPH_SCHED_CLAMP_EN (negative finite results written as +0.0).
module iph_sweep_scheduler
  import iph_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned LAT  = LAT_DEFAULT,
  parameter int unsigned TW   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH*SINGLE-1:0] S_all,
  input  logic [N_CH*SINGLE-1:0] T_all,
  output logic                   iss_vld,
  output logic [SINGLE-1:0]      iss_S,
  output logic [SINGLE-1:0]      iss_T,
  input  logic                   dp_done,
  input  logic [SINGLE-1:0]      dp_Iph,
  output logic [N_CH*SINGLE-1:0] Iph_all,
  output logic [N_CH-1:0]        Iph_vld,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   align_err
);

  sched_state_e r_state, w_state_nxt;

  logic [N_CH-1:0]        r_rem;       // enabled channels not yet issued
  logic [N_CH-1:0]        w_rem_nxt;
  logic [N_CH*SINGLE-1:0] r_s_sh, r_t_sh, r_iph;
  logic [N_CH-1:0]        r_iph_vld;
  logic [SINGLE-1:0]      r_iss_s, r_iss_t, w_sel_s, w_sel_t, w_wb;
  logic [TW-1:0]          w_ch, w_head_tag;
  logic                   w_snap, w_issue, w_head_vld, w_inflight;
  logic                   r_pend, r_align_err;

  // Lowest-index channel still waiting to issue.
  always_comb begin
    w_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_rem[k]) w_ch = TW'(k);
    end
  end

  assign w_rem_nxt = r_rem & (r_rem - N_CH'(1));
  assign w_sel_s   = r_s_sh[w_ch*SINGLE +: SINGLE];
  assign w_sel_t   = r_t_sh[w_ch*SINGLE +: SINGLE];

  // Next state, snapshot strobe and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_issue     = 1'b0;
    sweep_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start || r_pend) begin
          w_snap      = 1'b1;
          w_state_nxt = (ch_en == '0) ? StFin : StIssue;
        end
      end
      StIssue: begin
        w_issue = 1'b1;
        if (w_rem_nxt == '0) w_state_nxt = StDrain;
      end
      StDrain: begin
        // Only the head may still be valid; it retires on this edge.
        if (!w_inflight) w_state_nxt = StFin;
      end
      StFin: begin
        sweep_done = 1'b1;
        if (r_pend) begin
          w_snap      = 1'b1;
          w_state_nxt = (ch_en == '0) ? StFin : StIssue;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_nxt;
  end

  // Operand shadows, issue bookkeeping and one-deep pending start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem   <= '0;
      r_s_sh  <= '0;
      r_t_sh  <= '0;
      r_iss_s <= '0;
      r_iss_t <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (w_snap) begin
        r_rem  <= ch_en;
        r_s_sh <= S_all;
        r_t_sh <= T_all;
      end else if (w_issue) begin
        r_rem <= w_rem_nxt;
      end
      if (w_issue) begin
        r_iss_s <= w_sel_s;
        r_iss_t <= w_sel_t;
      end
      // Consuming the pending flag drops any start arriving in the same cycle.
      if (w_snap)                         r_pend <= 1'b0;
      else if (start && r_state != StIdle) r_pend <= 1'b1;
    end
  end

  iph_tag_pipe #(
    .LAT(LAT),
    .TW (TW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (w_issue),
    .i_tag     (w_ch),
    .o_head_vld(w_head_vld),
    .o_head_tag(w_head_tag),
    .o_inflight(w_inflight)
  );

  // Value written back for the head entry.
  always_comb begin
    w_wb = dp_Iph;
`ifdef IPH_SCHED_CLAMP_EN
    if (dp_Iph[SINGLE-1] && (dp_Iph[FP_EXP_MSB:FP_EXP_LSB] != '1)) w_wb = FP_ZERO;
`endif
  end

  // Result writeback by tag, independent of FSM state; alignment monitor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iph       <= '0;
      r_iph_vld   <= '0;
      r_align_err <= 1'b0;
    end else begin
      if (w_snap) r_iph_vld <= '0;
      if (w_head_vld) begin
        r_iph[w_head_tag*SINGLE +: SINGLE] <= w_wb;
        r_iph_vld[w_head_tag]              <= 1'b1;
      end
      if (dp_done != w_head_vld) r_align_err <= 1'b1;
    end
  end

  assign iss_vld   = w_issue;
  assign iss_S     = w_issue ? w_sel_s : r_iss_s;
  assign iss_T     = w_issue ? w_sel_t : r_iss_t;
  assign Iph_all   = r_iph;
  assign Iph_vld   = r_iph_vld;
  assign busy      = (r_state != StIdle);
  assign align_err = r_align_err;

endmodule

// File: tb/tb_iph_sweep_scheduler.sv
// Self-checking bench for iph_sweep_scheduler with a behavioural datapath and sweep model.
module tb_iph_sweep_scheduler;
  import iph_pkg::*;

  localparam int N_CH = 4;
  localparam int LAT  = 19;

  logic                   clk, rst, start;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH*SINGLE-1:0] S_all, T_all;
  logic                   iss_vld;
  logic [SINGLE-1:0]      iss_S, iss_T;
  logic                   dp_done;
  logic [SINGLE-1:0]      dp_Iph;
  logic [N_CH*SINGLE-1:0] Iph_all;
  logic [N_CH-1:0]        Iph_vld;
  logic                   busy, sweep_done, align_err;

  iph_sweep_scheduler #(
    .N_CH(N_CH),
    .LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ch_en     (ch_en),
    .S_all     (S_all),
    .T_all     (T_all),
    .iss_vld   (iss_vld),
    .iss_S     (iss_S),
    .iss_T     (iss_T),
    .dp_done   (dp_done),
    .dp_Iph    (dp_Iph),
    .Iph_all   (Iph_all),
    .Iph_vld   (Iph_vld),
    .busy      (busy),
    .sweep_done(sweep_done),
    .align_err (align_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [31:0] val;
  } dp_ent_t;

  typedef struct {
    logic [3:0] mask;
    int         exp_done;
    int         exp_niss;
  } vec_t;

  int          checks, errors, cyc, base;
  dp_ent_t     dp_q[$];
  int          iss_cyc_q[$];
  logic [31:0] iss_s_q[$];
  logic [31:0] iss_t_q[$];
  int          done_q[$];
  int          first_vld[N_CH];
  logic [31:0] exp_iph[N_CH];
  logic [31:0] cur_s[N_CH], cur_t[N_CH], alt_s[N_CH], alt_t[N_CH];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in datapath arithmetic.
  function automatic logic [31:0] dp_func(input logic [31:0] s, input logic [31:0] t);
    return s ^ t;
  endfunction

  // Value the result register should hold for one channel.
  function automatic logic [31:0] model_iph(input logic [31:0] s, input logic [31:0] t);
    logic [31:0] r;
    r = dp_func(s, t);
`ifdef IPH_SCHED_CLAMP_EN
    if (r[31] && r[30:23] != 8'hFF) r = 32'h0;
`endif
    return r;
  endfunction

  // One clock cycle: observe mid-cycle, then drive datapath outputs for the next cycle.
  task automatic tick();
    #4;
    if (!rst) dp_q.delete();
    if (iss_vld) begin
      iss_cyc_q.push_back(cyc - base);
      iss_s_q.push_back(iss_S);
      iss_t_q.push_back(iss_T);
      dp_q.push_back('{due: cyc + LAT, val: dp_func(iss_S, iss_T)});
    end
    if (sweep_done) done_q.push_back(cyc - base);
    for (int k = 0; k < N_CH; k++)
      if (Iph_vld[k] && first_vld[k] < 0) first_vld[k] = cyc - base;
    @(posedge clk);
    #1;
    cyc++;
    dp_done = 1'b0;
    dp_Iph  = $urandom;
    if (rst && dp_q.size() > 0 && dp_q[0].due == cyc) begin
      dp_done = 1'b1;
      dp_Iph  = dp_q[0].val;
      void'(dp_q.pop_front());
    end
  endtask

  task automatic load_cur();
    for (int k = 0; k < N_CH; k++) begin
      S_all[k*SINGLE +: SINGLE] = cur_s[k];
      T_all[k*SINGLE +: SINGLE] = cur_t[k];
    end
  endtask

  task automatic rand_vals();
    for (int k = 0; k < N_CH; k++) begin
      cur_s[k] = $urandom;
      cur_t[k] = $urandom;
      alt_s[k] = $urandom;
      alt_t[k] = $urandom;
    end
  endtask

  // Start a sweep at relative cycle 0; extra start pulses at cycles s2/s3 (-1 = none).
  task automatic run(input logic [3:0] mask, input int ncyc, input int s2, input int s3);
    iss_cyc_q.delete();
    iss_s_q.delete();
    iss_t_q.delete();
    done_q.delete();
    load_cur();
    base  = cyc;
    ch_en = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      first_vld[k] = -1;
      S_all[k*SINGLE +: SINGLE] = alt_s[k];
      T_all[k*SINGLE +: SINGLE] = alt_t[k];
    end
    for (int r = 1; r < ncyc; r++) begin
      start = (r == s2 || r == s3);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic verify_sweep(input string tag, input logic [3:0] mask, input int exp_done,
                              input int exp_niss);
    int j;
    check($sformatf("%s done count", tag), done_q.size(), 1);
    if (done_q.size() > 0) check($sformatf("%s done cycle", tag), done_q[0], exp_done);
    check($sformatf("%s issue count", tag), iss_cyc_q.size(), exp_niss);
    j = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (mask[k]) begin
        exp_iph[k] = model_iph(cur_s[k], cur_t[k]);
        if (j < iss_cyc_q.size()) begin
          check($sformatf("%s issue%0d cycle", tag, j), iss_cyc_q[j], 1 + j);
          check($sformatf("%s issue%0d S", tag, j), iss_s_q[j], cur_s[k]);
          check($sformatf("%s issue%0d T", tag, j), iss_t_q[j], cur_t[k]);
        end
        check($sformatf("%s ch%0d write cycle", tag, k), first_vld[k], j + LAT + 2);
        j++;
      end
    end
    for (int k = 0; k < N_CH; k++)
      check($sformatf("%s Iph ch%0d", tag, k), Iph_all[k*SINGLE +: SINGLE], exp_iph[k]);
    check($sformatf("%s Iph_vld", tag), Iph_vld, mask);
    check($sformatf("%s align_err", tag), align_err, 1'b0);
    check($sformatf("%s busy after", tag), busy, 1'b0);
  endtask

  initial begin
    logic [3:0]  m;
    int          pc, ed;
    logic [31:0] clamp_exp;
    logic [31:0] exp_s;

    checks = 0;
    errors = 0;
    cyc    = 0;
    base   = 0;
    start  = 1'b0;
    ch_en  = '0;
    S_all  = '0;
    T_all  = '0;
    dp_done = 1'b0;
    dp_Iph  = '0;
    for (int k = 0; k < N_CH; k++) begin
      exp_iph[k]   = '0;
      first_vld[k] = -1;
    end

    vecs[0] = '{mask: 4'b1111, exp_done: 24, exp_niss: 4};
    vecs[1] = '{mask: 4'b1010, exp_done: 22, exp_niss: 2};
    vecs[2] = '{mask: 4'b0000, exp_done: 1,  exp_niss: 0};
    vecs[3] = '{mask: 4'b0100, exp_done: 21, exp_niss: 1};
    vecs[4] = '{mask: 4'b1001, exp_done: 22, exp_niss: 2};
    vecs[5] = '{mask: 4'b0111, exp_done: 23, exp_niss: 3};

    // Reset state
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("reset iss_vld", iss_vld, 1'b0);
    check("reset iss_S", iss_S, 32'h0);
    check("reset iss_T", iss_T, 32'h0);
    check("reset Iph_all", Iph_all, '0);
    check("reset Iph_vld", Iph_vld, '0);
    check("reset busy", busy, 1'b0);
    check("reset sweep_done", sweep_done, 1'b0);
    check("reset align_err", align_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Table-driven sweeps; the first uses the reference irradiance set
    for (int i = 0; i < 6; i++) begin
      rand_vals();
      if (i == 0) begin
        cur_s[0] = 32'h447A0000;
        cur_s[1] = 32'h44480000;
        cur_s[2] = 32'h44160000;
        cur_s[3] = 32'h43C80000;
      end
      run(vecs[i].mask, vecs[i].exp_done + 3, -1, -1);
      verify_sweep($sformatf("vec%0d", i), vecs[i].mask, vecs[i].exp_done, vecs[i].exp_niss);
    end

    // Negative result on ch2, -Inf on ch3
    rand_vals();
    cur_s[2] = 32'hBF800000;
    cur_t[2] = 32'h0;
    cur_s[3] = 32'hFF800000;
    cur_t[3] = 32'h0;
    run(4'b1111, 27, -1, -1);
`ifdef IPH_SCHED_CLAMP_EN
    clamp_exp = 32'h00000000;
`else
    clamp_exp = 32'hBF800000;
`endif
    check("clamp ch2", Iph_all[2*SINGLE +: SINGLE], clamp_exp);
    check("neg inf ch3", Iph_all[3*SINGLE +: SINGLE], 32'hFF800000);
    verify_sweep("clamp", 4'b1111, 24, 4);

    // Randomized masks and operands
    for (int i = 0; i < 8; i++) begin
      rand_vals();
      m  = 4'($urandom_range(0, 15));
      pc = 0;
      for (int k = 0; k < N_CH; k++) pc += int'(m[k]);
      ed = (pc == 0) ? 1 : pc + LAT + 1;
      run(m, ed + 3, -1, -1);
      verify_sweep($sformatf("rand%0d", i), m, ed, pc);
    end

    // Pending start at 5 runs one more sweep; start at 6 is lost
    rand_vals();
    run(4'b1111, 60, 5, 6);
    check("pend done count", done_q.size(), 2);
    if (done_q.size() > 0) check("pend done0", done_q[0], 24);
    if (done_q.size() > 1) check("pend done1", done_q[1], 48);
    check("pend issue count", iss_cyc_q.size(), 8);
    for (int j = 0; j < 8; j++) begin
      if (j < iss_cyc_q.size()) begin
        exp_s = (j < 4) ? cur_s[j] : alt_s[j-4];
        check($sformatf("pend issue%0d cycle", j), iss_cyc_q[j], (j < 4) ? 1 + j : 21 + j);
        check($sformatf("pend issue%0d S", j), iss_s_q[j], exp_s);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      exp_iph[k] = model_iph(alt_s[k], alt_t[k]);
      check($sformatf("pend Iph ch%0d", k), Iph_all[k*SINGLE +: SINGLE], exp_iph[k]);
    end
    check("pend Iph_vld", Iph_vld, 4'b1111);
    check("pend busy after", busy, 1'b0);

    // Reset mid-sweep discards everything in flight
    rand_vals();
    iss_cyc_q.delete();
    iss_s_q.delete();
    iss_t_q.delete();
    done_q.delete();
    load_cur();
    base  = cyc;
    ch_en = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 1; r < 30; r++) begin
      if (r == 10) begin
        rst = 1'b0;
        #1;
        check("rst iss_vld", iss_vld, 1'b0);
        check("rst iss_S", iss_S, 32'h0);
        check("rst busy", busy, 1'b0);
        check("rst Iph_all", Iph_all, '0);
        check("rst Iph_vld", Iph_vld, '0);
      end
      if (r == 12) rst = 1'b1;
      tick();
    end
    for (int k = 0; k < N_CH; k++) exp_iph[k] = '0;
    check("rst done count", done_q.size(), 0);
    check("rst issue count", iss_cyc_q.size(), 4);
    check("rst no writeback vld", Iph_vld, '0);
    check("rst no writeback data", Iph_all, '0);
    check("rst align_err", align_err, 1'b0);
    check("rst busy after", busy, 1'b0);

    // Spurious done with no valid tag
    tick();
    dp_done = 1'b1;
    tick();
    check("align set", align_err, 1'b1);
    repeat (5) tick();
    check("align held", align_err, 1'b1);
    rst = 1'b0;
    #1;
    check("align cleared by reset", align_err, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
